// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and default parameters for the UART loopback.
package uart_pkg;

    localparam int CLKS_PER_BIT = 20;
    localparam int FIFO_AW      = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit first-word-fall-through FIFO with sticky overrun/underrun flags.
module uart_fifo #(
    parameter int FIFO_AW = uart_pkg::FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       dvalid,
    output logic       full,
    output logic       overrun,
    output logic       underrun
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push, do_pop;

    assign dvalid  = count != '0;
    assign full    = count == (FIFO_AW + 1)'(DEPTH);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && dvalid;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
            if (push && full && !pop) overrun <= 1'b1;
            if (pop && !dvalid) underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_loopback.sv
// uart_loopback: 8N1 receiver -> RX FIFO -> TX FIFO -> 8N1 transmitter, with status LEDs.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (RX timing +2 cycles).
module uart_loopback #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FIFO_AW      = uart_pkg::FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [2:0] rgb_led
);

    import uart_pkg::*;

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic rx_in;
`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else rx_sync <= {rx_sync[0], rx};
    end
    assign rx_in = rx_sync[1];
`else
    assign rx_in = rx;
`endif

    rx_state_t     rx_state;
    logic          rx_prev, framing_err, rx_tick, rx_push;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    assign rx_tick = rx_cnt == (rx_state == RX_START ? HALF_END : BIT_END);
    assign rx_push = rx_state == RX_STOP && rx_tick && rx_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_prev     <= 1'b1;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            framing_err <= 1'b0;
        end else begin
            rx_prev <= rx_in;
            rx_cnt  <= (rx_state == RX_IDLE || rx_state == RX_WAIT_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE:      if (rx_prev && !rx_in) rx_state <= RX_START;
                RX_START:     if (rx_tick) begin
                    rx_bit   <= '0;
                    rx_state <= rx_in ? RX_IDLE : RX_DATA;
                end
                RX_DATA:      if (rx_tick) begin
                    rx_shift <= {rx_in, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP:      if (rx_tick) begin
                    if (!rx_in) framing_err <= 1'b1;
                    rx_state <= rx_in ? RX_IDLE : RX_WAIT_IDLE;
                end
                RX_WAIT_IDLE: if (rx_in) rx_state <= RX_IDLE;
                default:      rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [7:0] rx_rdata, tx_rdata;
    logic       rx_dvalid, rx_full_unused, rx_overrun, rx_underrun;
    logic       tx_dvalid, tx_full, tx_overrun, tx_underrun;
    logic       xfer, tx_pop;

    assign xfer = rx_dvalid && !tx_full;

    uart_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .wdata    (rx_shift),
        .pop      (xfer),
        .rdata    (rx_rdata),
        .dvalid   (rx_dvalid),
        .full     (rx_full_unused),
        .overrun  (rx_overrun),
        .underrun (rx_underrun)
    );

    uart_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (xfer),
        .wdata    (rx_rdata),
        .pop      (tx_pop),
        .rdata    (tx_rdata),
        .dvalid   (tx_dvalid),
        .full     (tx_full),
        .overrun  (tx_overrun),
        .underrun (tx_underrun)
    );

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign tx_tick = tx_cnt == BIT_END;
    // Popping on the last stop-bit cycle chains frames without an idle gap.
    assign tx_pop  = tx_dvalid && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_shift <= tx_rdata;
                tx_state <= TX_START;
            end else begin
                case (tx_state)
                    TX_START: if (tx_tick) begin
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                    TX_DATA:  if (tx_tick) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    end
                    TX_STOP:  if (tx_tick) tx_state <= TX_IDLE;
                    default:  tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;

    assign rgb_led = {~(rx_overrun | tx_overrun | rx_underrun | tx_underrun),
                      ~(tx_state != TX_IDLE),
                      ~framing_err};

endmodule

// File: tb/tb_uart_loopback.sv
// tb_uart_loopback: directed self-checking bench for the UART loopback echo path.
module tb_uart_loopback;

    localparam int CPB = 20;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [2:0] rgb_led;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int rx_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_loopback #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .tx      (tx),
        .rgb_led (rgb_led)
    );

    // Must be entered at a negedge; leaves rx high at a negedge, ready for the next frame.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        rx_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic capture(input logic [7:0] exp, output logic [7:0] b, output int f,
                           output int bad, output bit green_ok, output bit ok);
        logic [9:0] fr, exp_fr;
        int n;
        exp_fr = {1'b1, exp, 1'b0};
        fr = '1; n = 0; bad = 0; f = 0; green_ok = 1'b1; ok = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 600);
        if (tx === 1'b0) begin
            ok = 1'b1;
            f = cyc;
            for (int j = 0; j < 10 * CPB; j++) begin
                if (j > 0) @(negedge clk);
                if (j % CPB == CPB / 2) fr[j / CPB] = tx;
                if (tx !== exp_fr[j / CPB]) bad++;
                if (rgb_led[1] !== 1'b0) green_ok = 1'b0;
            end
        end
        b = fr[8:1];
    endtask

    task automatic quiet(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    task automatic echo(input string name, input logic [7:0] d);
        logic [7:0] b;
        int f, bad;
        bit g, ok;
        @(negedge clk);
        fork
            send_frame(d, 1'b1);
            capture(d, b, f, bad, g, ok);
        join
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: tx never fell, expected start bit within 600 cycles", name);
        end else begin
            checks++;
            if (b !== d) begin
                errors++;
                $display("FAIL %s_byte: got %h expected %h", name, b, d);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL %s_waveform: %0d wrong tx cycles, expected 0", name, bad);
            end
        end
    endtask

    task automatic test_reset();
        int bad_tx, bad_led, lows;
        bad_tx = 0; bad_led = 0;
        rst = 1'b1;
        rx = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (rgb_led !== 3'b111) bad_led++;
        end
        rst = 1'b0;
        checks++;
        if (bad_tx !== 0) begin
            errors++;
            $display("FAIL reset_tx: %0d cycles with tx low, expected 0", bad_tx);
        end
        checks++;
        if (bad_led !== 0) begin
            errors++;
            $display("FAIL reset_led: %0d cycles with rgb_led!=111, expected 0", bad_led);
        end
        quiet(500, lows);
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL reset_idle: %0d cycles tx low, expected 0", lows);
        end
        checks++;
        if (rgb_led !== 3'b111) begin
            errors++;
            $display("FAIL reset_led_idle: got %b expected 111", rgb_led);
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        int f, bad, lat;
        bit g, ok;
        @(negedge clk);
        fork
            send_frame(8'h48, 1'b1);
            capture(8'h48, b, f, bad, g, ok);
        join
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: tx never fell, expected start bit");
        end else begin
            lat = f - rx_start - (CPB / 2 + 9 * CPB + 1);
            checks++;
            if (b !== 8'h48) begin
                errors++;
                $display("FAIL single_byte: got %h expected 48", b);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL single_waveform: %0d wrong tx cycles, expected 0", bad);
            end
            checks++;
            if (lat < 0 || lat > LAT) begin
                errors++;
                $display("FAIL single_latency: got %0d cycles expected 0..%0d", lat, LAT);
            end
            checks++;
            if (!g) begin
                errors++;
                $display("FAIL single_green: rgb_led[1] high during frame, expected 0");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [4] = '{8'h48, 8'h2C, 8'h6A, 8'h1E};
        logic [7:0] b [4];
        int f [4];
        int bad [4];
        bit g [4];
        bit ok [4];
        @(negedge clk);
        fork
            for (int i = 0; i < 4; i++) send_frame(data[i], 1'b1);
            for (int k = 0; k < 4; k++) capture(data[k], b[k], f[k], bad[k], g[k], ok[k]);
        join
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok[i] || b[i] !== data[i] || bad[i] !== 0) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h (%0d bad cycles, found=%0d) expected %h",
                         i, b[i], bad[i], ok[i], data[i]);
            end
            if (i > 0) begin
                checks++;
                if (f[i] - f[i-1] !== 10 * CPB) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: start spacing %0d expected %0d", i, f[i] - f[i-1], 10 * CPB);
                end
            end
        end
        checks++;
        if (rgb_led[0] !== 1'b1 || rgb_led[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_led: got %b expected red and blue off", rgb_led);
        end
    endtask

    task automatic test_framing();
        int lows;
        @(negedge clk);
        send_frame(8'hA5, 1'b0);
        quiet(300, lows);
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL framing_no_tx: %0d cycles tx low, expected 0", lows);
        end
        checks++;
        if (rgb_led[0] !== 1'b0) begin
            errors++;
            $display("FAIL framing_red: got %b expected 0", rgb_led[0]);
        end
        echo("framing_next", 8'h3C);
        checks++;
        if (rgb_led[0] !== 1'b0 || rgb_led[2] !== 1'b1) begin
            errors++;
            $display("FAIL framing_sticky: got %b expected red on, blue off", rgb_led);
        end
    endtask

    task automatic test_glitch();
        int lows;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        quiet(300, lows);
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL glitch_no_tx: %0d cycles tx low, expected 0", lows);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        int lows;
        fr = {1'b1, 8'h81, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = fr[5];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || rgb_led !== 3'b111) begin
            errors++;
            $display("FAIL midreset_state: tx=%b rgb_led=%b expected tx=1 rgb_led=111", tx, rgb_led);
        end
        rst = 1'b0;
        quiet(300, lows);
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL midreset_no_tx: %0d cycles tx low, expected 0", lows);
        end
        echo("midreset_next", 8'h81);
        checks++;
        if (rgb_led[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_red: got %b expected 1", rgb_led[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
